// File: rtl/cla_nibble_sequencer_if.sv
// ---------------------------------------------------------------------------
// cla_nibble_sequencer_if
//
// Purpose:
//   Bundles the request and response handshakes of the nibble-serial CLA
//   sequencer into one interface. The ALU control front end connects through
//   the master modport. The sequencer connects through the slave modport.
//
// Parameters:
//   NIBBLES  number of 4-bit slices per operation (WIDTH = 4*NIBBLES).
//            Must match the NIBBLES of the attached sequencer.
//
// Signals:
//   in_valid   master -> slave  request carries valid operands
//   in_ready   slave  -> master sequencer can accept a request
//   op         master -> slave  0 = add, 1 = subtract
//   a, b       master -> slave  WIDTH-bit operands
//   cin        master -> slave  carry-in for add (ignored for subtract)
//   out_valid  slave  -> master result and flags valid
//   out_ready  master -> slave  consumer accepts result
//   result     slave  -> master WIDTH-bit sum/difference
//   carry_out  slave  -> master final carry (subtract: 1 = no borrow)
//   overflow   slave  -> master two's-complement signed overflow
//   zero       slave  -> master result == 0
//   busy       slave  -> master operation in flight or result pending
// ---------------------------------------------------------------------------
interface cla_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    // Front end side: issues requests and consumes results.
    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero, busy
    );

    // Sequencer side: accepts requests and produces results.
    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero, busy
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Purpose:
//   Multi-precision add/subtract built around one shared 4-bit
//   carry-lookahead slice. A WIDTH = 4*NIBBLES operand pair is accepted over
//   a valid/ready handshake. It is then pushed through the slice one nibble
//   per cycle, LSB nibble first, with the carry chained through a register.
//   The result is returned with carry, overflow and zero flags over a second
//   valid/ready handshake. Latency from accept to out_valid is NIBBLES
//   cycles.
//
// Parameters:
//   NIBBLES  slices per operation, legal range 1..16 (default 4).
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   bus    cla_nibble_sequencer_if slave modport (request/response handshakes,
//          operands, result, flags, busy)
//
// Contents:
//   carry_look_ahead_adder  4-bit CLA slice (pure combinational)
//   cla_nibble_sequencer    IDLE/RUN/DONE sequencer around one slice
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice. Every internal carry is built from the
// generate/propagate terms and c_in, so no ripple path crosses the slice.
module carry_look_ahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Expand all carries from the generate/propagate terms of the slice.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        s     = p ^ c[3:0];
        c_out = c[4];
    end
endmodule

module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    cla_nibble_sequencer_if.slave bus
);
    localparam int WIDTH = 4 * NIBBLES;
    // A single-nibble build still needs a 1-bit index register.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;
    logic             out_valid_reg;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] result_next;

    // Select the nibble for the current step. b_reg already holds ~b for a
    // subtract, so the slice always adds. The carry register supplies the
    // chained carry (or the initial cin / subtract "+1").
    always_comb begin
        slice_a = a_reg[4*int'(idx) +: 4];
        slice_b = b_reg[4*int'(idx) +: 4];
    end

    carry_look_ahead_adder u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_reg),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // The result as it will look after this step. The zero flag is taken
    // from here so that it includes the final nibble being written.
    always_comb begin
        result_next = result_reg;
        result_next[4*int'(idx) +: 4] = slice_s;
    end

    // Sequencer FSM. One always_ff owns every register, including the
    // registered outputs, so the flags and result change only on clock edges.
    // Requests in RUN/DONE are ignored outright; there is no queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx           <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1, so invert B here and seed
                        // the carry with 1.
                        a_reg      <= bus.a;
                        b_reg      <= bus.op ? ~bus.b : bus.b;
                        carry_reg  <= bus.op ? 1'b1 : bus.cin;
                        idx        <= '0;
                        result_reg <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_c;
                    if (idx == LAST_IDX) begin
                        // Signed overflow: operands (post-inversion) agree in
                        // sign but the top result bit disagrees.
                        carry_out_reg <= slice_c;
                        overflow_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                       & (slice_s[3] != a_reg[WIDTH-1]);
                        zero_reg      <= (result_next == '0);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // in_ready and busy decode straight from the state register; every other
    // output comes from a dedicated register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-precision add/subtract sequencer built around the team's 4-bit carry-lookahead adder slice (`carry_look_ahead_adder`). It accepts a WIDTH = 4*NIBBLES operand pair over a valid/ready handshake. It streams the operands through one CLA instance one nibble per cycle, LSB nibble first, and chains the carry through a register. It returns the result with carry, overflow and zero flags over a second valid/ready handshake. It sits between the ALU control front end and the single shared CLA slice, trading latency for area.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operation; WIDTH = 4*NIBBLES; legal range 1..16.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  sequencer can accept a request.
- op  input  1  0 = add (A + B + cin), 1 = subtract (A - B; cin ignored).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  final slice carry; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.
- busy  output  1  high in RUN or DONE.

## Operation
- One CLA instance, instantiated internally. Slice inputs: A = a_reg[4*idx+:4], B = b_reg[4*idx+:4], Cin = carry_reg.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. When in_valid & in_ready, latch a_reg = a. Latch b_reg = op ? ~b : b. Set carry_reg = op ? 1 : cin, idx = 0, clear result register, and go to RUN. Without in_valid, stay in IDLE.
- RUN: each cycle, write result[4*idx+:4] = slice S and carry_reg = slice C_out.
  - If idx == NIBBLES-1, capture flags and go to DONE.
  - Otherwise increment idx.
  - idx width is clog2(NIBBLES), minimum 1 bit.
- Flag capture on the last RUN cycle:
  - carry_out = C_out of the last slice.
  - overflow = (a_reg[MSB] == b_reg[MSB]) & (S[3] != a_reg[MSB]). b_reg is the post-inversion value.
  - zero = (full result including last nibble) == 0.
- DONE: out_valid = 1. result and flags hold stable until out_valid & out_ready, then go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid in those states is ignored; no request is queued.
- Inputs a, b, op and cin are sampled only on the accept edge. Later changes have no effect.
- Reset (rst_n = 0 at a rising edge), in any state including mid-RUN or DONE:
  - State goes to IDLE; the in-flight operation is discarded.
  - result = 0, carry_out = 0, overflow = 0, zero = 0, out_valid = 0, busy = 0, in_ready = 1 after the reset edge.
  - Internal a_reg, b_reg, carry_reg and idx are cleared.
- NIBBLES = 1: RUN lasts exactly one cycle.

## Timing
- Accept on edge T0: RUN during cycles T0..T0+NIBBLES-1 (edges T0+1..T0+NIBBLES).
- out_valid rises after edge T0+NIBBLES. Latency from accept to out_valid = NIBBLES cycles.
- Output handshake completes on edge Td (out_valid & out_ready). in_ready = 1 from Td onward, so the next accept is possible at edge Td+1.
- Maximum throughput: one operation per NIBBLES+2 cycles when out_ready is held high.
- All outputs are registered, except in_ready and busy, which decode directly from the state register. No combinational path from any input to any output.
- out_ready is ignored outside DONE.

## Test plan
- NIBBLES=4, add a=0x1234 b=0x4321 cin=0 -> result 0x5555, carry_out 0, overflow 0, zero 0; out_valid exactly 4 cycles after accept.
- Add a=0xFFFF b=0x0001 cin=0 -> result 0x0000, carry_out 1, zero 1, overflow 0. Then add a=0x7FFF b=0x0000 cin=1 -> 0x8000, overflow 1, carry_out 0.
- Subtract a=0x8000 b=0x0001 -> 0x7FFF, carry_out 1, overflow 1. Subtract a=0x0003 b=0x0005 -> 0xFFFE, carry_out 0, overflow 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result/flags stable, in_ready 0. Pulse in_valid with new operands during RUN/DONE -> ignored, first result unchanged.
- Reset mid-operation: assert rst_n=0 for one edge at idx=2 -> next cycle state IDLE, out_valid 0, result 0, in_ready 1. A fresh add 0x0001+0x0001 then returns 0x0002.
- NIBBLES=1 build: add a=0xF b=0x1 cin=0 -> result 0x0, carry_out 1, zero 1, out_valid 1 cycle after accept.
